// File: rtl/cnu_row_stream_if.sv
// Edge stream interface for cnu_row_stream: input edge handshake, output edge
// handshake, and the per-row statistics that accompany the output stream.
interface cnu_row_stream_if #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned LANES    = 4,
  parameter int unsigned DMAX     = 10,
  parameter int unsigned IDX_BITS = $clog2(DMAX)
);
  localparam int unsigned DegW = $clog2(DMAX + 1);

  logic                      i_valid;
  logic                      o_ready;
  logic                      i_last;
  logic [LANES*BITS-1:0]     i_gamma_old;
  logic [LANES*BITS-1:0]     i_beta_old;
  logic                      o_valid;
  logic                      i_ready;
  logic                      o_last;
  logic [LANES*BITS-1:0]     o_beta_new;
  logic [LANES*BITS-1:0]     o_gamma_new;
  logic [LANES*(BITS-1)-1:0] o_min1;
  logic [LANES*(BITS-1)-1:0] o_min2;
  logic [LANES*IDX_BITS-1:0] o_idx;
  logic [LANES-1:0]          o_sign;
  logic [DegW-1:0]           o_deg;

  // Row processor side.
  modport slave (
    input  i_valid, i_last, i_gamma_old, i_beta_old, i_ready,
    output o_ready, o_valid, o_last, o_beta_new, o_gamma_new,
    output o_min1, o_min2, o_idx, o_sign, o_deg
  );

  // Memory / scheduler side.
  modport master (
    output i_valid, i_last, i_gamma_old, i_beta_old, i_ready,
    input  o_ready, o_valid, o_last, o_beta_new, o_gamma_new,
    input  o_min1, o_min2, o_idx, o_sign, o_deg
  );
endinterface

// File: rtl/cnu_row_stream.sv
// Streaming layered offset-min-sum check-node row processor. ACCUM takes one
// edge per cycle, buffers saturated alpha values and tracks min1/min2/idx/sign
// per lane; EMIT replays the row producing new check messages and APP values.
module cnu_row_stream #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned LANES    = 4,
  parameter int unsigned DMAX     = 10,
  parameter int unsigned OFFSET   = 1,
  parameter int unsigned MAX      = 2 ** (BITS - 1) - 1,
  parameter int unsigned IDX_BITS = $clog2(DMAX)
) (
  input logic            clk,
  input logic            rst_n,
  cnu_row_stream_if.slave row
);
  localparam int unsigned DegW = $clog2(DMAX + 1);

  localparam logic [0:0] StAccum = 1'b0;
  localparam logic [0:0] StEmit  = 1'b1;

  localparam logic signed [BITS:0] MaxP  = (BITS + 1)'(MAX);
  localparam logic signed [BITS:0] MaxN  = -MaxP;
  localparam logic [BITS-2:0]      MaxM  = (BITS - 1)'(MAX);
  localparam logic [BITS-2:0]      OffM  = (BITS - 1)'(OFFSET);

  // Clamp a one-bit-wider signed value into [-MAX, MAX].
  function automatic logic [BITS-1:0] sat(input logic signed [BITS:0] x);
    if (x > MaxP)      return MaxP[BITS-1:0];
    else if (x < MaxN) return MaxN[BITS-1:0];
    else               return x[BITS-1:0];
  endfunction

  function automatic logic [BITS-1:0] sub_sat(input logic [BITS-1:0] g, input logic [BITS-1:0] b);
    logic signed [BITS:0] d;
    d = $signed({g[BITS-1], g}) - $signed({b[BITS-1], b});
    return sat(d);
  endfunction

  // Alpha is never -2^(BITS-1), so the magnitude always fits in BITS-1 bits.
  function automatic logic [BITS-2:0] abs_mag(input logic [BITS-1:0] a);
    logic [BITS-1:0] n;
    n = a[BITS-1] ? (~a + 1'b1) : a;
    return n[BITS-2:0];
  endfunction

  logic [0:0]                          state_q, state_d;
  logic [DegW-1:0]                     cnt_q, cnt_d;
  logic [DegW-1:0]                     j_q, j_d;
  logic [DegW-1:0]                     deg_q, deg_d;
  logic [LANES-1:0][BITS-2:0]          min1_q, min1_d;
  logic [LANES-1:0][BITS-2:0]          min2_q, min2_d;
  logic [LANES-1:0][IDX_BITS-1:0]      idx_q, idx_d;
  logic [LANES-1:0]                    sign_q, sign_d;
  logic [LANES-1:0][BITS-1:0]          buf_q [DMAX];

  logic [LANES-1:0][BITS-1:0]          alpha;
  logic [LANES-1:0][BITS-1:0]          beta_w, gamma_w;
  logic                                in_fire, in_last, out_fire, emit_last, first;
  logic [IDX_BITS-1:0]                 jx;
  logic [BITS-2:0]                     mag, b1, b2, m, bmag;
  logic [IDX_BITS-1:0]                 bi;
  logic                                bs;
  logic [BITS-1:0]                     a_j, b_j;

  assign in_fire   = row.i_valid && (state_q == StAccum);
  assign in_last   = row.i_last || (cnt_q == DegW'(DMAX - 1));
  assign out_fire  = (state_q == StEmit) && row.i_ready;
  assign emit_last = (j_q == deg_q - DegW'(1));
  assign first     = (cnt_q == '0);
  assign jx        = j_q[IDX_BITS-1:0];

  // Saturated alpha per lane and the running min/idx/sign update on accept.
  always_comb begin
    alpha  = '0;
    min1_d = min1_q;
    min2_d = min2_q;
    idx_d  = idx_q;
    sign_d = sign_q;
    mag    = '0;
    b1     = '0;
    b2     = '0;
    bi     = '0;
    bs     = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      alpha[l] = sub_sat(row.i_gamma_old[l*BITS +: BITS], row.i_beta_old[l*BITS +: BITS]);
      mag = abs_mag(alpha[l]);
      // First edge of a row compares against MAX instead of stale state.
      b1  = first ? MaxM : min1_q[l];
      b2  = first ? MaxM : min2_q[l];
      bi  = first ? '0 : idx_q[l];
      bs  = first ? 1'b0 : sign_q[l];
      if (in_fire) begin
        min1_d[l] = b1;
        min2_d[l] = b2;
        idx_d[l]  = bi;
        sign_d[l] = bs ^ alpha[l][BITS-1];
        // Strict compares keep the earlier index on ties.
        if (mag < b1) begin
          min2_d[l] = b1;
          min1_d[l] = mag;
          idx_d[l]  = cnt_q[IDX_BITS-1:0];
        end else if (mag < b2) begin
          min2_d[l] = mag;
        end
      end
    end
  end

  // Row sequencing: ACCUM counts accepted edges, EMIT walks j over the row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    deg_d   = deg_q;
    case (state_q)
      StAccum: begin
        if (in_fire) begin
          cnt_d = cnt_q + DegW'(1);
          if (in_last) begin
            state_d = StEmit;
            deg_d   = cnt_q + DegW'(1);
            j_d     = '0;
          end
        end
      end
      default: begin
        if (out_fire) begin
          if (emit_last) begin
            state_d = StAccum;
            cnt_d   = '0;
            j_d     = '0;
          end else begin
            j_d = j_q + DegW'(1);
          end
        end
      end
    endcase
  end

  // Output edge j: offset-min-sum message and updated APP, zero outside EMIT.
  always_comb begin
    beta_w  = '0;
    gamma_w = '0;
    a_j     = '0;
    b_j     = '0;
    m       = '0;
    bmag    = '0;
    for (int l = 0; l < LANES; l++) begin
      a_j  = buf_q[jx][l];
      m    = (jx == idx_q[l]) ? min2_q[l] : min1_q[l];
      bmag = (m > OffM) ? (m - OffM) : '0;
      b_j  = {1'b0, bmag};
      if (sign_q[l] ^ a_j[BITS-1]) b_j = -b_j;
      if (state_q == StEmit) begin
        beta_w[l]  = b_j;
        gamma_w[l] = sat($signed({a_j[BITS-1], a_j}) + $signed({b_j[BITS-1], b_j}));
      end
    end
  end

  // Control and per-row statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      cnt_q   <= '0;
      j_q     <= '0;
      deg_q   <= '0;
      min1_q  <= '0;
      min2_q  <= '0;
      idx_q   <= '0;
      sign_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      deg_q   <= deg_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
    end
  end

  // Alpha edge buffer, written at slot cnt on each accepted edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DMAX; k++) buf_q[k] <= '0;
    end else if (in_fire) begin
      buf_q[cnt_q[IDX_BITS-1:0]] <= alpha;
    end
  end

  assign row.o_ready     = (state_q == StAccum);
  assign row.o_valid     = (state_q == StEmit);
  assign row.o_last      = (state_q == StEmit) && emit_last;
  assign row.o_beta_new  = beta_w;
  assign row.o_gamma_new = gamma_w;
  assign row.o_min1      = min1_q;
  assign row.o_min2      = min2_q;
  assign row.o_idx       = idx_q;
  assign row.o_sign      = sign_q;
  assign row.o_deg       = deg_q;

endmodule

// File: doc/cnu_row_stream.md
# cnu_row_stream

Streaming layered min-sum row processor for the QC-LDPC decoder. It is the parametrised successor of the single-shot VNAP + CNU pairing. Per check row it accepts variable-node edges serially, one edge per cycle across `LANES` parallel circulant rows. It forms saturated alpha values, tracks min1/min2/index/sign, then replays the row, emitting offset-min-sum check messages and updated APP values. It sits between the APP/message memories and the layer scheduler, with valid/ready on both sides.

## Interface
- `BITS`, default 8: signed LLR/message width.
- `LANES`, default 4: parallel rows processed in lock-step.
- `DMAX`, default 10: maximum row degree (edge buffer depth).
- `OFFSET`, default 1: offset-min-sum subtraction; 0 gives plain min-sum.
- `MAX`, default 2**(BITS-1)-1: saturation magnitude.
- `IDX_BITS`, default $clog2(DMAX): edge index width.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  input edge valid.
- `o_ready`  out  1  block accepts an edge (high only in ACCUM).
- `i_last`  in  1  marks the final edge of the row.
- `i_gamma_old`  in  LANES*BITS  old APP per lane, signed, lane 0 in LSBs.
- `i_beta_old`  in  LANES*BITS  old check message per lane, signed.
- `o_valid`  out  1  output edge valid.
- `i_ready`  in  1  downstream accepts output edge.
- `o_last`  out  1  final output edge of the row.
- `o_beta_new`  out  LANES*BITS  new check message per lane.
- `o_gamma_new`  out  LANES*BITS  new APP per lane.
- `o_min1`, `o_min2`  out  LANES*(BITS-1)  row magnitudes, before offset.
- `o_idx`  out  LANES*IDX_BITS  edge position of min1.
- `o_sign`  out  LANES  XOR of all alpha signs.
- `o_deg`  out  $clog2(DMAX+1)  degree of the current row.

## Operation
- States: ACCUM and EMIT. Reset enters ACCUM.
- **ACCUM**
  - `o_ready`=1. An edge is accepted when `i_valid`&&`o_ready`.
  - Per lane, alpha = sat(gamma_old − beta_old) into [−MAX, MAX]. −2^(BITS-1) is never produced.
  - Alpha is stored in buffer slot cnt; cnt++ per accepted edge.
  - mag = |alpha|. sgn = alpha<0, so zero counts as positive.
  - If mag < min1: min2←min1, min1←mag, idx←cnt.
  - Else if mag < min2: min2←mag.
  - Ties keep the earlier index.
  - sign ^= sgn.
  - The first edge of a row initialises min1=min2=MAX, sign=0 before its compare.
- **ACCUM → EMIT** when the accepted edge has `i_last`=1, or cnt reaches DMAX (forced last). `o_deg` latches cnt+1.
- **EMIT**
  - `o_ready`=0, and `i_valid` is ignored.
  - Output edge j walks from 0 to deg−1.
  - m = (j==idx) ? min2 : min1. bmag = max(m−OFFSET, 0).
  - beta = (sign ^ sgn_j) ? −bmag : bmag.
  - gamma_new = sat(alpha_j + beta) into [−MAX, MAX].
  - j advances on `o_valid`&&`i_ready`. `o_last`=1 when j==deg−1.
- **EMIT → ACCUM** on the handshake of the last edge; cnt clears.
- Degree-1 row: min2 stays MAX, so its beta = ±(MAX−OFFSET).
- `o_min1`/`o_min2`/`o_idx`/`o_sign`/`o_deg` are stable for the whole EMIT phase. They are only meaningful while `o_valid`=1.

## Timing
- Reset (async assert) puts all outputs at 0 except `o_ready`=1. cnt=0, state ACCUM.
- Reset mid-row or mid-EMIT discards the row; no partial output follows.
- Last input handshake in cycle t gives `o_valid`=1 with edge 0 in cycle t+1.
- Output data derives combinationally from registered buffer and min state; no extra pipeline stage.
- With `i_ready` held high, edges emit one per cycle. The last output handshake in cycle u gives `o_ready`=1 in cycle u+1.
- Row cost is 2·deg cycles minimum; there is no overlap of ACCUM and EMIT.
- Backpressure: while `o_valid`=1 and `i_ready`=0, all outputs hold unchanged.
- `i_valid` gaps in ACCUM stall without state change.

## Test plan
- **Basic row**
  - Stimulus: LANES=1, BITS=8, OFFSET=1. gamma_old={5,−3,7,−3}, beta_old=0, i_last on edge 3.
  - Required response: min1=3, min2=3, idx=1, sign=0, deg=4. beta={2,−2,2,−2}, gamma_new={7,−5,9,−5}. o_last on edge 3.
- **Saturation**
  - Stimulus: gamma_old={120,−128}, beta_old={−100,0}.
  - Required response: alpha={127,−127}, min1=min2=127, idx=0, sign=1. beta={−126,126}, gamma_new={1,−1}.
- **Forced last**
  - Stimulus: 10 edges, DMAX=10, i_last never asserted.
  - Required response: EMIT after edge 9, deg=10, o_last on output 9, o_ready=1 the cycle after.
- **Backpressure and input gaps**
  - Stimulus: i_valid low 2 cycles mid-row; i_ready low 3 cycles at output edge 1.
  - Required response: results match the basic row. Outputs hold during the stall; no edge is dropped or duplicated.
- **Lanes and OFFSET=0**
  - Stimulus: LANES=4 with distinct rows per lane, OFFSET=0.
  - Required response: per-lane results match the reference model. beta magnitude equals min1/min2 exactly.
- **Reset mid-EMIT**
  - Stimulus: assert rst_n low at output edge 2.
  - Required response: o_valid falls immediately. After release, o_ready=1. The next basic row produces correct results.
